// File: rtl/router_pkg.sv
// Shared router types: port indices, allocator FSM states and port-index width.
package router_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_IDX_W = 3;

  typedef enum logic [PORT_IDX_W-1:0] {
    N = 3'd0,
    S = 3'd1,
    E = 3'd2,
    W = 3'd3,
    L = 3'd4
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: searches from ptr+1 (mod WIDTH) and returns
// the first requesting index.
module rr_arbiter_n #(
  parameter int unsigned WIDTH = 5,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             gnt_any_c
);

  int unsigned idx;

  // Walk the ring backwards so the nearest index after ptr is written last and wins.
  always_comb begin
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    idx       = 0;
    for (int unsigned k = WIDTH; k > 0; k--) begin
      idx = (32'(ptr) + k) % WIDTH;
      if (req[idx]) begin
        gnt_idx_c = IDX_W'(idx);
        gnt_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_alloc_ctrl.sv
// Wormhole switch allocator: XY routing, per-output round-robin lock until tail.
// Optional per-output flit counters are built when SWITCH_ALLOC_PERF_EN is defined.
module switch_alloc_ctrl
  import router_pkg::*;
#(
  parameter int unsigned          COORD_W   = 4,
  parameter logic [NUM_PORTS-1:0] PORT_MASK = 5'b10111
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2*COORD_W-1:0]                   local_addr,
  input  logic [NUM_PORTS-1:0][2*COORD_W-1:0]    packet_addr,
  input  logic [NUM_PORTS-1:0]                   packet_valid,
  input  logic [NUM_PORTS-1:0]                   packet_tail,
  input  logic [NUM_PORTS-1:0]                   buffer_full_in,
  output logic [NUM_PORTS-1:0][PORT_IDX_W-1:0]   grant_sel,
  output logic [NUM_PORTS-1:0]                   grant_v,
`ifdef SWITCH_ALLOC_PERF_EN
  output logic [NUM_PORTS-1:0][15:0]             flit_cnt,
`endif
  output logic [NUM_PORTS-1:0]                   pop_v
);

  localparam int unsigned ADDR_W = 2 * COORD_W;

  function automatic logic [PORT_IDX_W-1:0] xy_route(input logic [ADDR_W-1:0] loc,
                                                     input logic [ADDR_W-1:0] dst);
    logic [COORD_W-1:0] lx, ly, dx, dy;
    lx = loc[ADDR_W-1:COORD_W];
    ly = loc[COORD_W-1:0];
    dx = dst[ADDR_W-1:COORD_W];
    dy = dst[COORD_W-1:0];
    if (dx > lx)      return PORT_IDX_W'(E);
    else if (dx < lx) return PORT_IDX_W'(W);
    else if (dy > ly) return PORT_IDX_W'(N);
    else if (dy < ly) return PORT_IDX_W'(S);
    else              return PORT_IDX_W'(L);
  endfunction

  logic [NUM_PORTS-1:0][PORT_IDX_W-1:0] route;
  logic [NUM_PORTS-1:0]                 busy;
  logic [NUM_PORTS-1:0]                 owns;

  always_comb begin
    route = '0;
    for (int i = 0; i < NUM_PORTS; i++) route[i] = xy_route(local_addr, packet_addr[i]);
  end

  // An input holding a lock sends body flits only; its packet_addr is not re-routed.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        if (busy[o] && grant_sel[o] == PORT_IDX_W'(i)) owns[i] = 1'b1;
  end

  always_comb begin
    grant_v = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      grant_v[o] = busy[o] && packet_valid[grant_sel[o]] && !buffer_full_in[o];
  end

  always_comb begin
    pop_v = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int o = 0; o < NUM_PORTS; o++)
        if (grant_v[o] && grant_sel[o] == PORT_IDX_W'(i)) pop_v[i] = 1'b1;
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    if (PORT_MASK[o]) begin : g_present
      alloc_state_e          state_q;
      logic [PORT_IDX_W-1:0] owner_q;
      logic [PORT_IDX_W-1:0] rr_ptr_q;
      logic [PORT_IDX_W-1:0] win_idx_c;
      logic                  win_any_c;
      logic [NUM_PORTS-1:0]  req_c;

      always_comb begin
        req_c = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          req_c[i] = packet_valid[i] && !owns[i] && PORT_MASK[i] &&
                     (route[i] == PORT_IDX_W'(o)) && !((o == i) && (i != int'(L)));
      end

      rr_arbiter_n #(.WIDTH(NUM_PORTS)) u_arb (
        .req       (req_c),
        .ptr       (rr_ptr_q),
        .gnt_idx_c (win_idx_c),
        .gnt_any_c (win_any_c)
      );

      // rr_ptr resets to L so the first search after reset starts at N.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q  <= IDLE;
          owner_q  <= '0;
          rr_ptr_q <= PORT_IDX_W'(L);
        end else begin
          case (state_q)
            IDLE: if (win_any_c) begin
              state_q  <= BUSY;
              owner_q  <= win_idx_c;
              rr_ptr_q <= win_idx_c;
            end
            BUSY: if (grant_v[o] && packet_tail[owner_q]) state_q <= IDLE;
            default: state_q <= IDLE;
          endcase
        end
      end

      assign busy[o]      = (state_q == BUSY);
      assign grant_sel[o] = owner_q;
    end else begin : g_absent
      assign busy[o]      = 1'b0;
      assign grant_sel[o] = '0;
    end
  end

`ifdef SWITCH_ALLOC_PERF_EN
  localparam int unsigned CNT_W = 16;

  // Saturating count of transfer cycles per output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++)
        if (grant_v[o] && flit_cnt[o] != {CNT_W{1'b1}}) flit_cnt[o] <= flit_cnt[o] + CNT_W'(1);
    end
  end
`endif

endmodule
